// File: rtl/acc_pkg.sv
// Shared types and default widths for the accumulator
// datapath and its sequencer.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } acc_state_e;

    localparam int ACC_INPUT_NUM  = 1;
    localparam int ACC_WDP        = 9;
    localparam int ACC_WDP_WEIGHT = 9;
    localparam int ACC_WDP_BIAS   = 13;
    localparam int ACC_MAX_GROUP  = 256;
    localparam int ACC_MAX_OUT    = 256;

endpackage

// File: rtl/acc_seq_addr.sv
// Beat/output counters and SRAM address generation for acc_seq.
// The weight address steps by one per issued beat, so no multiplier.
import acc_pkg::*;

module acc_seq_addr #(
    parameter int MAX_GROUP = ACC_MAX_GROUP,
    parameter int MAX_OUT   = ACC_MAX_OUT,
    localparam int GW = $clog2(MAX_GROUP + 1),
    localparam int OW = $clog2(MAX_OUT + 1),
    localparam int DA = $clog2(MAX_GROUP),
    localparam int WA = $clog2(MAX_GROUP * MAX_OUT),
    localparam int BA = $clog2(MAX_OUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          issue,
    input  logic [GW-1:0] n_group,
    input  logic [OW-1:0] n_out,
    output logic [DA-1:0] beat,
    output logic [BA-1:0] o_idx,
    output logic [WA-1:0] w_addr,
    output logic          first_beat,
    output logic          last_beat,
    output logic          last_out
);

    logic [DA-1:0] beat_q, beat_d;
    logic [BA-1:0] o_q, o_d;
    logic [WA-1:0] w_q, w_d;

    assign first_beat = (beat_q == '0);
    assign last_beat  = (GW'(beat_q) == n_group - GW'(1));
    assign last_out   = (OW'(o_q) == n_out - OW'(1));

    always_comb begin
        beat_d = beat_q;
        o_d    = o_q;
        w_d    = w_q;
        if (clear) begin
            beat_d = '0;
            o_d    = '0;
            w_d    = '0;
        end else if (issue) begin
            w_d = w_q + WA'(1);
            if (last_beat) begin
                beat_d = '0;
                o_d    = o_q + BA'(1);
            end else begin
                beat_d = beat_q + DA'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            o_q    <= '0;
            w_q    <= '0;
        end else begin
            beat_q <= beat_d;
            o_q    <= o_d;
            w_q    <= w_d;
        end
    end

    assign beat   = beat_q;
    assign o_idx  = o_q;
    assign w_addr = w_q;

endmodule

// File: rtl/acc_seq.sv
// Sequencer feeding acc for one fully-connected layer pass:
// issues feature/weight/bias reads and counts returning results.
import acc_pkg::*;

module acc_seq #(
    parameter int INPUT_NUM  = ACC_INPUT_NUM,
    parameter int WDP        = ACC_WDP,
    parameter int WDP_WEIGHT = ACC_WDP_WEIGHT,
    parameter int WDP_BIAS   = ACC_WDP_BIAS,
    parameter int MAX_GROUP  = ACC_MAX_GROUP,
    parameter int MAX_OUT    = ACC_MAX_OUT,
    localparam int GW = $clog2(MAX_GROUP + 1),
    localparam int OW = $clog2(MAX_OUT + 1),
    localparam int DA = $clog2(MAX_GROUP),
    localparam int WA = $clog2(MAX_GROUP * MAX_OUT),
    localparam int BA = $clog2(MAX_OUT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [GW-1:0]                  n_group,
    input  logic [OW-1:0]                  n_out,
    input  logic                           stall,
    output logic                           d_rd,
    output logic [DA-1:0]                  d_addr,
    input  logic [WDP*INPUT_NUM-1:0]       d_rdata,
    output logic                           w_rd,
    output logic [WA-1:0]                  w_addr,
    input  logic [WDP_WEIGHT*INPUT_NUM-1:0] w_rdata,
    output logic                           b_rd,
    output logic [BA-1:0]                  b_addr,
    input  logic [WDP_BIAS-1:0]            b_rdata,
    output logic                           acc_en,
    output logic                           acc_first,
    output logic                           acc_last,
    output logic [WDP*INPUT_NUM-1:0]       acc_data,
    output logic [WDP_WEIGHT*INPUT_NUM-1:0] acc_weight,
    output logic [WDP_BIAS-1:0]            acc_bias,
    input  logic                           q_en,
    output logic                           busy,
    output logic                           done
);

    acc_state_e    state_q, state_d;
    logic [GW-1:0] ng_q, ng_d;
    logic [OW-1:0] no_q, no_d;
    logic [OW-1:0] res_q, res_d;
    logic          en_q, en_d;
    logic          first_q, first_d;
    logic          last_q, last_d;

    logic          clear, issue;
    logic          first_beat, last_beat, last_out;

    assign clear = (state_q == IDLE) && start;
    assign issue = (state_q == RUN) && !stall;

    acc_seq_addr #(
        .MAX_GROUP (MAX_GROUP),
        .MAX_OUT   (MAX_OUT)
    ) u_addr (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .issue      (issue),
        .n_group    (ng_q),
        .n_out      (no_q),
        .beat       (d_addr),
        .o_idx      (b_addr),
        .w_addr     (w_addr),
        .first_beat (first_beat),
        .last_beat  (last_beat),
        .last_out   (last_out)
    );

    always_comb begin
        state_d = state_q;
        ng_d    = ng_q;
        no_d    = no_q;
        res_d   = res_q;
        en_d    = issue;
        first_d = issue && first_beat;
        last_d  = issue && last_beat;
        if (state_q != IDLE && q_en) begin
            res_d = res_q + OW'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    ng_d  = n_group;
                    no_d  = n_out;
                    res_d = '0;
                    if (n_group == '0 || n_out == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issue && last_beat && last_out) begin
                    state_d = DRAIN;
                end
            end
            // res_d already includes a q_en arriving this cycle
            DRAIN: begin
                if (res_d >= no_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ng_q    <= '0;
            no_q    <= '0;
            res_q   <= '0;
            en_q    <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ng_q    <= ng_d;
            no_q    <= no_d;
            res_q   <= res_d;
            en_q    <= en_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign d_rd       = issue;
    assign w_rd       = issue;
    assign b_rd       = issue && first_beat;
    assign acc_en     = en_q;
    assign acc_first  = first_q;
    assign acc_last   = last_q;
    assign acc_data   = d_rdata;
    assign acc_weight = w_rdata;
    assign acc_bias   = b_rdata;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_acc_seq.sv
// Self-checking bench for acc_seq: SRAM/acc stand-ins, a
// pass-level reference model, directed pins and random passes.
module tb_acc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  n_group = '0;
    logic [8:0]  n_out = '0;
    logic        stall = 1'b0;
    logic        q_en = 1'b0;
    logic        d_rd, w_rd, b_rd;
    logic [7:0]  d_addr, b_addr;
    logic [15:0] w_addr;
    logic [8:0]  d_rdata, w_rdata, acc_data, acc_weight;
    logic [12:0] b_rdata, acc_bias;
    logic        acc_en, acc_first, acc_last, busy, done;

    int checks = 0;
    int errors = 0;

    acc_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .n_group(n_group), .n_out(n_out), .stall(stall),
        .d_rd(d_rd), .d_addr(d_addr), .d_rdata(d_rdata),
        .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
        .b_rd(b_rd), .b_addr(b_addr), .b_rdata(b_rdata),
        .acc_en(acc_en), .acc_first(acc_first), .acc_last(acc_last),
        .acc_data(acc_data), .acc_weight(acc_weight), .acc_bias(acc_bias),
        .q_en(q_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] fd(int a);
        return 9'(a * 37 + 5);
    endfunction
    function automatic logic [8:0] fw(int a);
        return 9'(a * 11 + 1);
    endfunction
    function automatic logic [12:0] fb(int a);
        return 13'(a * 101 + 7);
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // SRAM stand-ins with one cycle of read latency
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdata <= '0;
            w_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (d_rd) d_rdata <= fd(int'(d_addr));
            if (w_rd) w_rdata <= fw(int'(w_addr));
            if (b_rd) b_rdata <= fb(int'(b_addr));
        end
    end

    // Reference model: a pass is k = 0..ng*no-1 issued beats,
    // then completion once no results have been counted.
    int m_ng, m_no, m_total, m_k, m_res;
    bit m_act, m_donep, m_rd, m_drained;
    bit e_en, e_first, e_last;
    logic [8:0]  e_d, e_w;
    logic [12:0] e_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_donep = 0; m_k = 0; m_res = 0;
            m_ng = 0; m_no = 0; m_total = 0;
            e_en = 0; e_first = 0; e_last = 0;
        end else begin
            m_rd = m_act && (m_k < m_total) && !stall;
            e_en = m_rd;
            e_first = 0;
            e_last = 0;
            if (m_rd) begin
                e_first = (m_k % m_ng) == 0;
                e_last = (m_k % m_ng) == m_ng - 1;
                e_d = fd(m_k % m_ng);
                e_w = fw(m_k);
                e_b = fb(m_k / m_ng);
            end
            if (m_donep) begin
                m_donep = 0;
            end else if (m_act) begin
                m_drained = (m_k == m_total);
                if (m_rd) m_k++;
                if (q_en) m_res++;
                if (m_drained && m_res >= m_no) begin
                    m_act = 0;
                    m_donep = 1;
                end
            end else if (start) begin
                m_ng = int'(n_group);
                m_no = int'(n_out);
                m_total = m_ng * m_no;
                m_k = 0;
                m_res = 0;
                if (m_total == 0) m_donep = 1;
                else m_act = 1;
            end
        end
    end

    always @(negedge clk) begin
        bit xr;
        if (!rst) begin
            xr = m_act && (m_k < m_total) && !stall;
            chk("d_rd", d_rd, xr);
            chk("w_rd", w_rd, xr);
            chk("b_rd", b_rd, xr && (m_k % m_ng == 0));
            if (xr) begin
                chk("d_addr", d_addr, m_k % m_ng);
                chk("w_addr", w_addr, m_k % 65536);
                chk("b_addr", b_addr, (m_k / m_ng) % 256);
            end
            chk("acc_en", acc_en, e_en);
            chk("acc_first", acc_first, e_first);
            chk("acc_last", acc_last, e_last);
            if (e_en) begin
                chk("acc_data", acc_data, e_d);
                chk("acc_weight", acc_weight, e_w);
            end
            if (e_first) chk("acc_bias", acc_bias, e_b);
            chk("busy", busy, m_act);
            chk("done", done, m_donep);
        end
    end

    // acc stand-in: one q_en per observed acc_last
    bit q_auto = 1;
    bit q_rand = 0;
    int pend = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst || !q_auto) pend = 0;
            else if (acc_last) pend++;
            @(posedge clk);
            #1;
            if (q_auto) begin
                if (pend > 0 && (!q_rand || $urandom_range(0, 1) == 1)) begin
                    q_en = 1;
                    pend--;
                end else begin
                    q_en = 0;
                end
            end
        end
    end

    int dq[$], wq[$], bq[$], enc[$], fq[$], lq[$];
    int dn, done_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(int ng, int no);
        n_group = 9'(ng);
        n_out = 9'(no);
        start = 1;
        tick();
        start = 0;
        n_group = 9'($urandom);
        n_out = 9'($urandom);
    endtask

    task automatic capture(int n);
        dq.delete(); wq.delete(); bq.delete();
        enc.delete(); fq.delete(); lq.delete();
        dn = 0;
        done_cyc = -1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (d_rd) dq.push_back(int'(d_addr));
            if (w_rd) wq.push_back(int'(w_addr));
            if (b_rd) bq.push_back(int'(b_addr));
            if (acc_en) begin
                enc.push_back(c);
                fq.push_back(int'(acc_first));
                lq.push_back(int'(acc_last));
            end
            if (done) begin
                dn++;
                done_cyc = c;
            end
        end
        tick();
    endtask

    task automatic wait_done(int max);
        bit seen = 0;
        int c = 0;
        while (!seen && c < max) begin
            @(negedge clk);
            if (done) seen = 1;
            c++;
        end
        chk("done_timeout", seen, 1);
        tick();
    endtask

    task automatic chk_q(string nm, int q[$], int exp[$]);
        chk({nm, "_len"}, q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < q.size(); i++)
            chk(nm, q[i], exp[i]);
    endtask

    bit rnd_on;

    initial begin
        #2;
        chk("rst_d_rd", d_rd, 0);
        chk("rst_addr", int'(d_addr) + int'(w_addr) + int'(b_addr), 0);
        chk("rst_acc", {acc_en, acc_first, acc_last}, 0);
        chk("rst_stat", {busy, done}, 0);
        tick();
        rst = 0;
        tick();

        // n_group=3, n_out=2
        do_start(3, 2);
        capture(30);
        chk_q("t1_d", dq, '{0, 1, 2, 0, 1, 2});
        chk_q("t1_w", wq, '{0, 1, 2, 3, 4, 5});
        chk_q("t1_b", bq, '{0, 1});
        chk_q("t1_first", fq, '{1, 0, 0, 1, 0, 0});
        chk_q("t1_last", lq, '{0, 0, 1, 0, 0, 1});
        chk("t1_en_cycle", enc.size() > 0 ? enc[0] : -1, 2);
        chk("t1_done_cnt", dn, 1);

        // n_group=1, n_out=4
        do_start(1, 4);
        capture(30);
        chk_q("t2_first", fq, '{1, 1, 1, 1});
        chk_q("t2_last", lq, '{1, 1, 1, 1});
        chk_q("t2_en", enc, '{2, 3, 4, 5});
        chk_q("t2_b", bq, '{0, 1, 2, 3});

        // stall bubble
        do_start(4, 1);
        fork
            begin
                tick(); tick();
                stall = 1;
                tick(); tick();
                stall = 0;
            end
            capture(20);
        join
        chk_q("t3_en", enc, '{2, 3, 6, 7});
        chk_q("t3_d", dq, '{0, 1, 2, 3});

        // zero outputs, then start during busy
        do_start(5, 0);
        capture(4);
        chk("t4_done_cyc", done_cyc, 1);
        chk("t4_reads", dq.size(), 0);
        do_start(2, 2);
        fork
            begin
                tick();
                n_group = 7; n_out = 7; start = 1;
                tick();
                start = 0;
            end
            capture(30);
        join
        chk("t4_reads2", dq.size(), 4);
        chk("t4_done_cnt", dn, 1);

        // reset mid-RUN
        do_start(3, 3);
        tick(); tick();
        rst = 1;
        #1;
        chk("t5_rd", {d_rd, w_rd, b_rd}, 0);
        chk("t5_addr", int'(d_addr) + int'(w_addr) + int'(b_addr), 0);
        chk("t5_acc", {acc_en, acc_first, acc_last}, 0);
        chk("t5_data", int'(acc_data) + int'(acc_weight) + int'(acc_bias), 0);
        chk("t5_stat", {busy, done}, 0);
        tick();
        rst = 0;
        tick();
        do_start(2, 1);
        capture(20);
        chk_q("t5_d", dq, '{0, 1});
        chk_q("t5_w", wq, '{0, 1});
        chk("t5_done_cnt", dn, 1);

        // q_en on the last issue cycle
        q_auto = 0;
        q_en = 0;
        tick();
        do_start(2, 2);
        fork
            begin
                tick(); tick();
                q_en = 1;
                tick(); tick();
                q_en = 0;
            end
            capture(12);
        join
        chk("t6_done_cyc", done_cyc, 6);
        q_auto = 1;

        // randomized passes
        q_rand = 1;
        for (int p = 0; p < 40; p++) begin
            int ng, no;
            ng = (p == 0) ? 256 : int'($urandom_range(0, 6));
            no = (p == 0) ? 2 : int'($urandom_range(0, 5));
            do_start(ng, no);
            rnd_on = 1;
            fork
                begin
                    while (rnd_on) begin
                        stall = ($urandom_range(0, 3) == 0);
                        tick();
                    end
                    stall = 0;
                end
                begin
                    wait_done(3000);
                    rnd_on = 0;
                end
            join
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
